// File: rtl/decodificador_teclado.sv
// 4x4 matrix keypad scanner/decoder: row scan, debounce, one-cycle key strobe.
// Optional auto-repeat while a key is held: define TECLADO_AUTO_REPEAT_EN.
module decodificador_teclado #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_matriz,
  output logic [3:0] lin_matriz,
  output logic [3:0] tecla_value,
  output logic       tecla_valid
);

  // The synchronizer delays columns by two cycles, so a row must be driven
  // at least that long before its sample reflects it.
  localparam int SETTLE  = (SCAN_CYCLES < 2) ? 2 : SCAN_CYCLES;
  localparam int CNT_MAX = (SETTLE > DEBOUNCE_CYCLES) ? SETTLE : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, HOLD, RELEASE} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       row_reg, row_next;
  logic [1:0]       col_reg, col_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       value_reg, value_next;
  logic [3:0]       col_meta_reg, col_sync_reg;
  logic             single;
  logic [1:0]       hit_col;
  logic [3:0]       key_pat;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_reg <= 4'hF;
      col_sync_reg <= 4'hF;
    end else begin
      col_meta_reg <= col_matriz;
      col_sync_reg <= col_meta_reg;
    end
  end

  always_comb begin
    single  = 1'b1;
    hit_col = 2'd0;
    case (col_sync_reg)
      4'b1110: hit_col = 2'd0;
      4'b1101: hit_col = 2'd1;
      4'b1011: hit_col = 2'd2;
      4'b0111: hit_col = 2'd3;
      default: single  = 1'b0;
    endcase
  end

  assign key_pat     = ~(4'b0001 << col_reg);
  assign lin_matriz  = ~(4'b0001 << row_reg);
  assign tecla_value = value_reg;
  assign tecla_valid = (state_reg == EMIT);

`ifdef TECLADO_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] rep_cnt_reg, rep_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_cnt_reg <= '0;
    else      rep_cnt_reg <= rep_next;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= SCAN;
      row_reg   <= 2'd0;
      col_reg   <= 2'd0;
      cnt_reg   <= '0;
      value_reg <= 4'h0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      cnt_reg   <= cnt_next;
      value_reg <= value_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    cnt_next   = cnt_reg;
    value_next = value_reg;
`ifdef TECLADO_AUTO_REPEAT_EN
    rep_next   = '0;
`endif
    case (state_reg)
      SCAN: begin
        if (cnt_reg == CNT_W'(SETTLE)) begin
          cnt_next = '0;
          if (single) begin
            col_next   = hit_col;
            state_next = DEBOUNCE;
          end else begin
            row_next = row_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_sync_reg == key_pat) begin
          if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_next   = '0;
            value_next = key_code(row_reg, col_reg);
            state_next = EMIT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          cnt_next   = '0;
          row_next   = row_reg + 2'd1;
          state_next = SCAN;
        end
      end
      EMIT: begin
        cnt_next   = '0;
        state_next = HOLD;
      end
      HOLD: begin
        if (col_sync_reg == 4'hF) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end
`ifdef TECLADO_AUTO_REPEAT_EN
        // Hold timer spans the EMIT cycle too, so strobes are REPEAT_CYCLES apart.
        else if (!col_sync_reg[col_reg]) begin
          if (rep_cnt_reg == REP_W'(REPEAT_CYCLES - 2)) begin
            state_next = EMIT;
          end else begin
            rep_next = rep_cnt_reg + 1'b1;
          end
        end
`endif
      end
      RELEASE: begin
        if (col_sync_reg != 4'hF) begin
          cnt_next   = '0;
          state_next = HOLD;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_next   = '0;
          row_next   = row_reg + 2'd1;
          state_next = SCAN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_decodificador_teclado.sv
// Scoreboard bench for decodificador_teclado with a behavioural keypad matrix.
// Define TECLADO_AUTO_REPEAT_EN for both RTL and bench to cover auto-repeat.
module tb_decodificador_teclado;

  logic       clk;
  logic       rst;
  logic [3:0] col_matriz;
  logic [3:0] lin_matriz;
  logic [3:0] tecla_value;
  logic       tecla_valid;

  logic [15:0] keys;          // keys[r*4+c] = pressed
  logic [3:0]  exp_q[$];
  int          pulse_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic        prev_valid = 1'b0;

  decodificador_teclado #(
    .SCAN_CYCLES(2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_matriz(col_matriz),
    .lin_matriz(lin_matriz),
    .tecla_value(tecla_value),
    .tecla_valid(tecla_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col_matriz = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !lin_matriz[r]) col_matriz[c] = 1'b0;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: every strobe is matched against the scoreboard.
  initial forever begin
    logic [3:0] exp;
    @(negedge clk);
    if (tecla_valid === 1'b1) begin
      checks++;
      pulse_cyc.push_back(cyc);
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_width: got valid high two cycles in a row, required single-cycle strobe");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got pulse value %h, required no pulse", tecla_value);
      end else begin
        exp = exp_q.pop_front();
        if (tecla_value !== exp) begin
          errors++;
          $display("FAIL pulse_value: got %h, required %h", tecla_value, exp);
        end else begin
          $display("pulse value %h at cycle %0d ok", tecla_value, cyc);
        end
      end
    end
    prev_valid = (tecla_valid === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_row_start(input int r, output bit ok);
    logic [3:0] pat;
    int n;
    pat = 4'hF;
    pat[r] = 1'b0;
    n = 0;
    while (lin_matriz == pat && n < 200) begin @(negedge clk); n++; end
    while (lin_matriz != pat && n < 200) begin @(negedge clk); n++; end
    ok = (lin_matriz == pat);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    logic [3:0] seq [4];
    logic [3:0] last;
    int n;
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
    rst = 1'b0;
    keys = '0;
    #1;
    checks++;
    if (lin_matriz !== 4'b1110) begin errors++; $display("FAIL reset_lin: got %b, required 1110", lin_matriz); end
    checks++;
    if (tecla_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", tecla_valid); end
    checks++;
    if (tecla_value !== 4'h0) begin errors++; $display("FAIL reset_value: got %h, required 0", tecla_value); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last = lin_matriz;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (lin_matriz == last && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (lin_matriz !== seq[i]) begin
        errors++;
        $display("FAIL row_rotation[%0d]: got %b, required %b", i, lin_matriz, seq[i]);
      end else begin
        $display("row step %0d -> %b ok", i, lin_matriz);
      end
      last = lin_matriz;
    end
  endtask

  task automatic test_single_press();
    bit ok;
    wait_row_start(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_align: got no row1, required row1 scan"); end
    exp_q.push_back(4'h5);
    keys[1*4+1] = 1'b1;
    repeat (12) @(negedge clk);
    keys = '0;
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_pulse: got %0d missing, required 0", exp_q.size()); end
    checks++;
    if (tecla_value !== 4'h5) begin errors++; $display("FAIL single_hold_value: got %h, required 5", tecla_value); end
    exp_q.delete();
  endtask

  task automatic test_bounce();
    bit ok;
    wait_row_start(0, ok);
    for (int i = 0; i < 5; i++) begin
      keys[3] = 1'b1;
      repeat (2) @(negedge clk);
      keys[3] = 1'b0;
      repeat (2) @(negedge clk);
    end
    exp_q.push_back(4'hA);
    keys[3] = 1'b1;
    wait_drain(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bounce_pulse: got no pulse, required pulse A"); end
    repeat (2) @(negedge clk);
    keys = '0;
    exp_q.delete();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_ghost();
    bit ok;
    keys[3*4+0] = 1'b1;
    keys[3*4+2] = 1'b1;
    repeat (40) @(negedge clk);
    exp_q.push_back(4'hE);
    keys[3*4+2] = 1'b0;
    wait_drain(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ghost_pulse: got no pulse, required pulse E"); end
    repeat (2) @(negedge clk);
    keys = '0;
    exp_q.delete();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_sequence();
    int rr [5];
    int cc [5];
    logic [3:0] code [5];
    bit ok;
    rr = '{0, 0, 0, 0, 1};
    cc = '{0, 1, 2, 3, 3};
    code = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB};
    for (int i = 0; i < 5; i++) begin
      wait_row_start(rr[i], ok);
      exp_q.push_back(code[i]);
      keys[rr[i]*4+cc[i]] = 1'b1;
      repeat (12) @(negedge clk);
      keys = '0;
      repeat (12) @(negedge clk);
    end
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sequence: got %0d pulses missing, required 0", exp_q.size()); end
    exp_q.delete();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_hold_repeat();
    bit ok;
    wait_row_start(3, ok);
    pulse_cyc.delete();
    exp_q.push_back(4'h0);
`ifdef TECLADO_AUTO_REPEAT_EN
    repeat (3) exp_q.push_back(4'h0);
`endif
    keys[3*4+1] = 1'b1;
    repeat (60) @(negedge clk);
    keys = '0;
    wait_drain(40, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_pulses: got %0d missing, required 0", exp_q.size()); end
`ifdef TECLADO_AUTO_REPEAT_EN
    checks++;
    if (pulse_cyc.size() != 4) begin
      errors++; $display("FAIL repeat_count: got %0d, required 4", pulse_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (pulse_cyc[i] - pulse_cyc[i-1] != 16) begin
          errors++;
          $display("FAIL repeat_interval[%0d]: got %0d, required 16", i, pulse_cyc[i] - pulse_cyc[i-1]);
        end
      end
    end
`else
    checks++;
    if (pulse_cyc.size() != 1) begin errors++; $display("FAIL hold_count: got %0d, required 1", pulse_cyc.size()); end
`endif
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    bit ok;
    int n;
    // Mid-debounce: key 9 seen on row2, reset before acceptance.
    wait_row_start(2, ok);
    keys[2*4+2] = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (lin_matriz !== 4'b1110 || tecla_valid !== 1'b0) begin
      errors++; $display("FAIL abort_debounce: got lin %b valid %b, required 1110 0", lin_matriz, tecla_valid);
    end
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    // Mid-hold: key 5 accepted, reset while still held.
    wait_row_start(1, ok);
    exp_q.push_back(4'h5);
    keys[1*4+1] = 1'b1;
    wait_drain(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_hold_pulse: got no pulse, required pulse 5"); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (lin_matriz !== 4'b1110 || tecla_value !== 4'h0) begin
      errors++; $display("FAIL abort_hold_reset: got lin %b value %h, required 1110 0", lin_matriz, tecla_value);
    end
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (lin_matriz == 4'b1110 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (lin_matriz !== 4'b1101) begin errors++; $display("FAIL restart_row: got %b, required 1101", lin_matriz); end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    keys = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_ghost();
    test_sequence();
    test_hold_repeat();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decodificador_teclado.md
DECODIFICADOR_TECLADO -- requirements
Module: decodificador_teclado

Interface
REQ-001 Parameter SCAN_CYCLES, default 1000: clock cycles each row is driven before its columns are sampled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000: consecutive identical samples required to accept a press or a release.
REQ-003 Parameter REPEAT_CYCLES, default 500000: hold interval between auto-repeat emissions; used only when REQ-030 is compiled in.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port col_matriz, input, 4: keypad columns; active-low with external pull-ups; asynchronous to clk.
REQ-007 Port lin_matriz, output, 4: keypad rows; exactly one bit low (driven row), the others high.
REQ-008 Port tecla_value, output, 4: code of the accepted key; held stable between emissions.
REQ-009 Port tecla_valid, output, 1: one-cycle strobe marking a new tecla_value; this is the producer side of the digit/valid handshake consumed by the setup and operational blocks.

Function
REQ-010 col_matriz SHALL pass through a 2-flop synchronizer before any use; all "sample" references mean the synchronized value.
REQ-011 Key map, row r / column c: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = *,0,#,D.
REQ-012 Codes: digits 0-9 → 4'h0-4'h9; A-D → 4'hA-4'hD; * → 4'hE; # → 4'hF.
REQ-013 States SHALL be SCAN, DEBOUNCE, EMIT, HOLD and RELEASE.
REQ-014 SCAN: drive row r low for SCAN_CYCLES cycles, then sample.
REQ-015 SCAN, no column low: advance to row (r+1) mod 4, wrapping 3→0.
REQ-016 SCAN, exactly one column low: latch r and c, go to DEBOUNCE.
REQ-017 SCAN, two or more columns low: treat as no key and advance the row.
REQ-018 DEBOUNCE: keep row r driven and count consecutive cycles whose sample equals the latched pattern.
REQ-019 DEBOUNCE, count reaches DEBOUNCE_CYCLES: go to EMIT.
REQ-020 DEBOUNCE, any differing sample: clear the count, return to SCAN on row (r+1) mod 4, emit nothing.
REQ-021 EMIT: lasts exactly one cycle; update tecla_value and pulse tecla_valid=1; next state HOLD.
REQ-022 tecla_valid SHALL never be high on two consecutive cycles.
REQ-023 HOLD: keep row r driven; when all four columns sample high, go to RELEASE.
REQ-024 RELEASE: return to SCAN on row (r+1) mod 4 after DEBOUNCE_CYCLES consecutive all-high samples; any low sample returns to HOLD.
REQ-025 A second key pressed while in HOLD or RELEASE SHALL be ignored until full release.

Reset
REQ-026 On rst=0, immediately and asynchronously: state=SCAN, row=0, lin_matriz=4'b1110, tecla_value=4'h0, tecla_valid=0, all counters and synchronizer flops cleared (synchronizer flops to high, i.e. idle columns).
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort with no emission; after release, scanning restarts at row 0.
REQ-028 Outputs SHALL update synchronously from the first clk edge after rst rises.

Configuration
REQ-029 Macro TECLADO_AUTO_REPEAT_EN SHALL select the auto-repeat feature.
REQ-030 With the macro defined: in HOLD, after REPEAT_CYCLES cycles with the same key still low, re-emit that key (one-cycle tecla_valid), restart the hold timer, and repeat until release.
REQ-031 Without the macro: one emission per press regardless of hold duration; the REPEAT_CYCLES counter SHALL be absent from the netlist.

Verification (bench parameters: SCAN_CYCLES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
REQ-032 Reset: rst low → lin_matriz=4'b1110, tecla_valid=0, tecla_value=0; with no key pressed, rows rotate 1110→1101→1011→0111→1110.
REQ-033 Single press: hold row1/col1 low ≥10 cycles → exactly one tecla_valid pulse with tecla_value=4'h5; release → no further pulse.
REQ-034 Bounce: row0/col3 toggled low/high every 2 cycles for 20 cycles, then held low → no pulse during bounce, then one pulse with 4'hA.
REQ-035 Ghost/multi-key: row3 col0+col2 low together → no pulse; then release col2 only (col0 remains low) → one pulse with 4'hE.
REQ-036 Sequence 1,2,3,A,B, each press 12 cycles with 12-cycle gaps → five pulses with values 1,2,3,A,B in order.
REQ-037 Hold row3/col1 for 60 cycles → one pulse 4'h0 without TECLADO_AUTO_REPEAT_EN; with it, first pulse followed by further pulses every 16 cycles; rst pulse mid-hold → no further emission.
